// File: rtl/analyzer_pkg.sv
// Shared definitions for the analyzer front-panel logic.
// State encodings and board-level timing defaults.
package analyzer_pkg;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_SETTLE = 1'b1
  } db_state_t;

  // One lockout of about 200 ms at the 100 MHz board clock.
  localparam int CLK_WAIT_DEFAULT = 20000000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after the last grant.
// Also reused by the capture-channel mux.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         any,
  output logic [W-1:0] gnt
);

  // Scan from the far end so the nearest requester after 'last' wins.
  always_comb begin
    any = 1'b0;
    gnt = last;
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(last) + i) % N]) begin
        any = 1'b1;
        gnt = W'((int'(last) + i) % N);
      end
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// Multi-channel button debouncer sharing one lockout counter,
// handed out round-robin to channels whose synced input moved.
module debounce_scheduler
  import analyzer_pkg::*;
#(
  parameter int N_BTN    = 4,
  parameter int CLK_WAIT = CLK_WAIT_DEFAULT
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_BTN-1:0]         i_buttons,
  output logic [N_BTN-1:0]         o_level,
  output logic [N_BTN-1:0]         o_press,
  output logic [N_BTN-1:0]         o_release,
  output logic                     o_busy,
  output logic [$clog2(N_BTN)-1:0] o_grant
);

  localparam int GW = $clog2(N_BTN);
  localparam int CW = $clog2(CLK_WAIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_WAIT - 1);

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] req;
  logic             any;
  logic [GW-1:0]    gnt;

  db_state_t        state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] rel_q, rel_d;
  logic             busy_q, busy_d;
  logic [GW-1:0]    grant_q, grant_d;

  assign req = sync2 ^ level_q;

  rr_arbiter #(
    .N (N_BTN),
    .W (GW)
  ) u_arb (
    .req  (req),
    .last (grant_q),
    .any  (any),
    .gnt  (gnt)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1   <= '0;
      sync2   <= '0;
      state_q <= S_IDLE;
      count_q <= '0;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      busy_q  <= 1'b0;
      grant_q <= GW'(N_BTN - 1);
    end else begin
      sync1   <= i_buttons;
      sync2   <= sync1;
      state_q <= state_d;
      count_q <= count_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    level_d = level_q;
    press_d = '0;
    rel_d   = '0;
    busy_d  = busy_q;
    grant_d = grant_q;
    unique case (state_q)
      S_IDLE: begin
        if (any) begin
          level_d[gnt] = sync2[gnt];
          if (sync2[gnt]) press_d[gnt] = 1'b1;
          else            rel_d[gnt]   = 1'b1;
          grant_d = gnt;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = rel_q;
  assign o_busy    = busy_q;
  assign o_grant   = grant_q;

endmodule
